// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: geometry defaults and FSM state encoding.
package inst_cache_pkg;

    localparam int DEF_INDEX_BITS  = 4;
    localparam int DEF_OFFSET_BITS = 4;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int WORD_W          = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RESP
    } state_t;

    function automatic int line_words(input int offset_bits);
        return 2 ** (offset_bits - 2);
    endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Direct-mapped valid/tag/data storage: async read by index, one full-line write port.
module inst_cache_array
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = 24,
    parameter int LINE_WORDS = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INDEX_BITS-1:0]              rd_index,
    output logic                               rd_valid,
    output logic [TAG_BITS-1:0]                rd_tag,
    output logic [LINE_WORDS-1:0][WORD_W-1:0]  rd_line,
    input  logic                               we,
    input  logic [INDEX_BITS-1:0]              wr_index,
    input  logic [TAG_BITS-1:0]                wr_tag,
    input  logic [LINE_WORDS-1:0][WORD_W-1:0]  wr_line
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]                      valid;
    logic [TAG_BITS-1:0]                   tags [LINES];
    logic [LINE_WORDS-1:0][WORD_W-1:0]     data [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = data[rd_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_line;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, word-by-word line refill from the arbiter.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  _clear,
    input  logic                  _fetch_valid,
    input  logic [ADDR_WIDTH-1:0] _pc,
    output logic                  _inst_ready_out,
    output logic [31:0]           _inst_out,
    output logic                  _mem_req,
    output logic [ADDR_WIDTH-1:0] _mem_addr,
    input  logic                  _mem_ready_in,
    input  logic [31:0]           _mem_data_in
);

    localparam int LINE_WORDS = line_words(OFFSET_BITS);
    localparam int WORD_BITS  = OFFSET_BITS - 2;
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int TAG_LO     = OFFSET_BITS + INDEX_BITS;

    state_t                              state;
    logic                                abort;
    logic [ADDR_WIDTH-1:0]               pc_q;
    logic [WORD_BITS-1:0]                cnt;
    logic [LINE_WORDS-1:0][WORD_W-1:0]   fill_buf;
    logic [LINE_WORDS-1:0][WORD_W-1:0]   fill_line;

    logic                                rd_valid;
    logic [TAG_BITS-1:0]                 rd_tag;
    logic [LINE_WORDS-1:0][WORD_W-1:0]   rd_line;

    logic [WORD_BITS-1:0]  pc_word, q_word;
    logic [INDEX_BITS-1:0] pc_index, q_index;
    logic [TAG_BITS-1:0]   pc_tag, q_tag;
    logic                  hit, cnt_last, fill_we;
    logic                  unused;

    assign pc_word  = _pc[OFFSET_BITS-1:2];
    assign pc_index = _pc[TAG_LO-1:OFFSET_BITS];
    assign pc_tag   = _pc[ADDR_WIDTH-1:TAG_LO];
    assign q_word   = pc_q[OFFSET_BITS-1:2];
    assign q_index  = pc_q[TAG_LO-1:OFFSET_BITS];
    assign q_tag    = pc_q[ADDR_WIDTH-1:TAG_LO];
    assign unused   = ^{_pc[1:0], pc_q[1:0]};

    assign hit      = rd_valid && (rd_tag == pc_tag);
    assign cnt_last = (cnt == WORD_BITS'(LINE_WORDS - 1));
    assign fill_we  = rdy_in && (state == S_FILL) && _mem_ready_in && cnt_last;

    // The last word goes straight from the bus into the installed line.
    always_comb begin
        fill_line      = fill_buf;
        fill_line[cnt] = _mem_data_in;
    end

    inst_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk      (clk_in),
        .rst      (rst_in),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (fill_we),
        .wr_index (q_index),
        .wr_tag   (q_tag),
        .wr_line  (fill_line)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= S_IDLE;
            abort           <= 1'b0;
            pc_q            <= '0;
            cnt             <= '0;
            fill_buf        <= '0;
            _inst_ready_out <= 1'b0;
            _inst_out       <= '0;
            _mem_req        <= 1'b0;
            _mem_addr       <= '0;
        end else if (rdy_in) begin
            _inst_ready_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (_fetch_valid && !_clear) begin
                        if (hit) begin
                            _inst_ready_out <= 1'b1;
                            _inst_out       <= rd_line[pc_word];
                        end else begin
                            pc_q      <= _pc;
                            cnt       <= '0;
                            abort     <= 1'b0;
                            _mem_req  <= 1'b1;
                            _mem_addr <= {_pc[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
                            state     <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    // A flush cannot cancel the line mid-burst; it only suppresses the response.
                    if (_clear) abort <= 1'b1;
                    if (_mem_ready_in) begin
                        fill_buf[cnt] <= _mem_data_in;
                        cnt           <= cnt + 1'b1;
                        _mem_addr     <= _mem_addr + ADDR_WIDTH'(4);
                        if (cnt_last) begin
                            _mem_req <= 1'b0;
                            if (abort || _clear) begin
                                state <= S_IDLE;
                            end else begin
                                state           <= S_RESP;
                                _inst_ready_out <= 1'b1;
                                _inst_out       <= fill_line[q_word];
                            end
                        end
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
